// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  localparam int UART_DATA_W  = 8;
  localparam int UART_MIN_DIV = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head output.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_n;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign rd_ptr_n = do_pop ? rd_ptr + AW'(1) : rd_ptr;

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= wr_data;
  end

  // A byte written into the slot that becomes the head is forwarded straight to rd_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      rd_ptr  <= rd_ptr_n;
      count   <= count + CW'(do_push) - CW'(do_pop);
      rd_data <= (do_push && (wr_ptr == rd_ptr_n)) ? wr_data : mem[rd_ptr_n];
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a byte FIFO with a valid/ready pop port and sticky error flags.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          rx_i,
  input  logic [15:0]                   clk_div,
  output logic [UART_DATA_W-1:0]        rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overrun,
  input  logic                          err_clr,
  input  logic                          irq_en,
  output logic                          irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] armed_q;
  logic                   line;
  logic                   armed;
  logic                   line_prev;
  logic                   fall;

  rx_state_e              state;
  logic [15:0]            div_eff;
  logic [15:0]            div_q;
  logic [15:0]            tick_cnt;
  logic [2:0]             bit_cnt;
  logic [UART_DATA_W-1:0] shreg;

  logic                   stop_tick;
  logic                   push_req;
  logic                   frame_set;
  logic                   pop_ok;
  logic                   push_ok;
  logic                   full;
  logic                   empty;
  logic                   overrun_set;
  logic [CW-1:0]          count_next;

  assign line  = sync_q[SYNC_STAGES-1];
  assign armed = armed_q[SYNC_STAGES-1];
  assign fall  = armed & line_prev & ~line;

  // armed_q holds off edge detection until the synchroniser carries real line values,
  // so a line that is already low when reset releases is not taken as a start bit.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sync_q    <= '1;
      armed_q   <= '0;
      line_prev <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], rx_i};
      armed_q   <= {armed_q[SYNC_STAGES-2:0], 1'b1};
      line_prev <= armed & line;
    end
  end

  assign div_eff = (clk_div < 16'(UART_MIN_DIV)) ? 16'(UART_MIN_DIV) : clk_div;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      div_q    <= 16'(UART_MIN_DIV);
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fall) begin
            div_q    <= div_eff;
            tick_cnt <= (div_eff >> 1) - 16'd1;
            bit_cnt  <= '0;
            state    <= START;
          end
        end
        START: begin
          if (tick_cnt == '0) begin
            if (!line) begin
              tick_cnt <= div_q - 16'd1;
              state    <= DATA;
            end else begin
              state <= IDLE;
            end
          end else begin
            tick_cnt <= tick_cnt - 16'd1;
          end
        end
        DATA: begin
          if (tick_cnt == '0) begin
            shreg    <= {line, shreg[UART_DATA_W-1:1]};
            tick_cnt <= div_q - 16'd1;
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7)
              state <= STOP;
          end else begin
            tick_cnt <= tick_cnt - 16'd1;
          end
        end
        STOP: begin
          if (tick_cnt == '0)
            state <= IDLE;
          else
            tick_cnt <= tick_cnt - 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stop_tick   = (state == STOP) && (tick_cnt == '0);
  assign push_req    = stop_tick & line;
  assign frame_set   = stop_tick & ~line;
  assign rx_valid    = ~empty;
  assign pop_ok      = rx_valid & rx_ready;
  assign push_ok     = push_req & (~full | pop_ok);
  assign overrun_set = push_req & full & ~pop_ok;
  assign count_next  = fifo_count + CW'(push_ok) - CW'(pop_ok);

  sync_fifo #(
    .WIDTH (UART_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .push    (push_req),
    .pop     (rx_ready),
    .wr_data (shreg),
    .rd_data (rx_data),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count)
  );

  // A new error event beats a simultaneous clear; irq tracks the occupancy being registered this edge.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      irq       <= 1'b0;
    end else begin
      frame_err <= frame_set | (frame_err & ~err_clr);
      overrun   <= overrun_set | (overrun & ~err_clr);
      irq       <= irq_en & (count_next != '0);
    end
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side UART for the user project: deserialises 8N1 frames arriving on the mprj_io[5] pad, such as those driven by the testbench UART model. Completed bytes are buffered in a small FIFO and handed to the firmware-facing Wishbone register block through a valid/ready pop interface, with an interrupt. It sits between the pad input and the UART CSR slave.

## Interface
- FIFO_DEPTH, 8: byte entries, power of two, 2..16.
- SYNC_STAGES, 2: input synchroniser flops, at least 2.

- wb_clk_i  in  1  system clock (40 MHz in simulation).
- wb_rst_i  in  1  asynchronous, active-high reset.
- rx_i  in  1  raw serial line, idle high, asynchronous to wb_clk_i.
- clk_div  in  16  clocks per bit. Values below 4 are treated as 4.
- rx_data  out  8  FIFO head byte. Valid when rx_valid=1.
- rx_valid  out  1  FIFO not empty.
- rx_ready  in  1  pop. A byte is consumed on any cycle where rx_valid && rx_ready.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- frame_err  out  1  sticky. Set when the stop bit is sampled as 0.
- overrun  out  1  sticky. Set when a byte is dropped because the FIFO is full.
- err_clr  in  1  single-cycle pulse that clears frame_err and overrun.
- irq_en  in  1  interrupt enable.
- irq  out  1  registered; equals irq_en && rx_valid.

## Operation
- The synchroniser resets to all 1s. Every reference to "line" below means the synchronised output.
- The FSM has four states: IDLE, START, DATA, STOP.
  - IDLE: on a falling edge of the line, latch clk_div into div_q, load bit_cnt=0, load tick_cnt=div_q/2 - 1, and go to START.
  - START: when tick_cnt reaches 0, sample the line. If it is 0, go to DATA and reload tick_cnt=div_q-1. If it is 1, treat it as a glitch and return to IDLE; nothing is pushed and no flag is set.
  - DATA: at each tick_cnt==0, shift the sample into shreg[7] (LSB first) and reload tick_cnt. After the 8th sample, go to STOP.
  - STOP: at tick_cnt==0, sample the line.
    - Sample is 1: push shreg.
    - Sample is 0: set frame_err and discard the byte.
    - In both cases go to IDLE. IDLE is re-armed immediately, so a back-to-back start bit half a bit later is caught.
- A clk_div change mid-frame takes effect only at the next start bit.
- Push and pop rules:
  - Push while full, with no simultaneous pop: drop the byte, set overrun, leave the FIFO unchanged.
  - Simultaneous push and pop when full: both succeed, overrun is not set.
  - Simultaneous push and pop when empty: the push succeeds and the pop is ignored, because rx_valid was 0.
  - Pop when empty: no effect. Pointers wrap modulo FIFO_DEPTH.
- Sticky flags:
  - err_clr in the same cycle as a new error event: the set wins.
  - Flags never clear the FIFO.

## Timing
- Reset values:
  - rx_valid=0, fifo_count=0, frame_err=0, overrun=0, irq=0, rx_data=0.
  - FSM in IDLE; synchroniser at 1.
- Reset asserted mid-frame aborts the frame, empties the FIFO and clears both flags. After release, the line must be seen high before a falling edge counts as a start bit.
- Sampling instants, measured from the first synchronised low cycle:
  - Start bit: div_q/2 cycles.
  - Data bit n: div_q/2 + (n+1)·div_q cycles.
  - Stop bit: div_q/2 + 9·div_q cycles.
- Latency:
  - rx_valid rises 1 cycle after the stop sample.
  - fifo_count and irq also update that cycle (irq is registered).
  - rx_data is registered from the read pointer; the next byte appears the cycle after a pop.
- Frame error: frame_err rises 1 cycle after the failing stop sample.
- Line to FSM delay: SYNC_STAGES cycles.

## Structure
- Shared package uart_pkg holds:
  - rx_state_e enum (IDLE, START, DATA, STOP).
  - UART_DATA_W=8.
  - UART_MIN_DIV=4.
- One sub-module: sync_fifo, parameterised by width and depth. It has push, pop, full, empty and count, with a registered read-data output. The top level contains the synchroniser, the FSM, the counters and the flags.

## Test plan
- clk_div=16, send 0xA5 then 0x3C back-to-back → rx_data shows 0xA5 then 0x3C; fifo_count reaches 2; no flags set.
- Send 9 bytes 0x00..0x08 with rx_ready=0 and FIFO_DEPTH=8 → fifo_count=8; overrun=1 after the 9th frame; popping returns 0x00..0x07.
- Frame 0x55 with stop bit forced 0 → frame_err=1; fifo_count unchanged. err_clr pulse → frame_err=0.
- Low glitch of 3 cycles on an idle line with clk_div=16 → FSM returns to IDLE; no push, no flags.
- FIFO full with rx_ready=1 held while a stop sample completes → push and pop in the same cycle; fifo_count stays 8; overrun=0.
- wb_rst_i asserted during DATA of frame 0x7E, then a clean 0x81 frame after release → only 0x81 is received; irq=1 with irq_en=1; irq falls the cycle after the FIFO empties.
